mips32_hazard_ctrl: RTL and testbench

//  Pipeline interlock/sequencing controller for the 5-stage pipe_MIPS32 (IF,ID,EX,MEM,WB).

---
 rtl/mips32_pkg.sv | 74 +++++++
 rtl/mips32_instr_decode.sv | 66 ++++++
 rtl/mips32_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_mips32_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 pipeline control logic: opcodes, instruction
// classes, field positions and the shadow-pipe entry format.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // OR R3,R3,R3: the dummy instruction the interlock makes unnecessary
  localparam logic [31:0] NOP_INSTR = 32'h0C63_1800;

  localparam int SH_STAGES = 3;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RR_ALU,
    CLS_RM_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_HALT
  } instr_class_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_hlt;
  } shadow_t;

  localparam shadow_t SH_BUBBLE = '0;

  function automatic logic [5:0] f_op(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  // R0 is hard-wired zero, so it can never carry a dependency
  function automatic logic src_match(input logic src_use, input logic [4:0] src,
                                     input logic [4:0] dest);
    return src_use && (src != 5'd0) && (src == dest);
  endfunction

endpackage

// File: rtl/mips32_instr_decode.sv
// Combinational instruction decode: class plus source/destination register usage.
module mips32_instr_decode
  import mips32_pkg::*;
(
  input  logic [31:0]  i_instr,
  output instr_class_e o_class,
  output logic         o_src1_use,
  output logic [4:0]   o_src1_idx,
  output logic         o_src2_use,
  output logic [4:0]   o_src2_idx,
  output logic         o_dest_use,
  output logic [4:0]   o_dest_idx
);

  // Immediate/offset bits carry no register information
  logic w_unused_imm;
  assign w_unused_imm = ^i_instr[RD_LO-1:0];

  assign o_src1_idx = f_rs(i_instr);
  assign o_src2_idx = f_rt(i_instr);

  // Map opcode to class and register usage; unknown opcodes use nothing
  always_comb begin
    o_class    = CLS_NONE;
    o_src1_use = 1'b0;
    o_src2_use = 1'b0;
    o_dest_use = 1'b0;
    o_dest_idx = f_rd(i_instr);
    case (f_op(i_instr))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        o_class    = CLS_RR_ALU;
        o_src1_use = 1'b1;
        o_src2_use = 1'b1;
        o_dest_use = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        o_class    = CLS_RM_ALU;
        o_src1_use = 1'b1;
        o_dest_use = 1'b1;
        o_dest_idx = f_rt(i_instr);
      end
      OP_LW: begin
        o_class    = CLS_LOAD;
        o_src1_use = 1'b1;
        o_dest_use = 1'b1;
        o_dest_idx = f_rt(i_instr);
      end
      OP_SW: begin
        o_class    = CLS_STORE;
        o_src1_use = 1'b1;
        o_src2_use = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: begin
        o_class    = CLS_BRANCH;
        o_src1_use = 1'b1;
      end
      OP_HLT: begin
        o_class = CLS_HALT;
      end
      default: begin
        o_class = CLS_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Pipeline interlock controller for the 5-stage MIPS32 pipe: RAW stalls with EX
// bubbles, taken-branch flush and HLT sequencing, driven by a shadow copy of the
// destination registers of instructions in EX, MEM and WB.
//
// halt sequencer | meaning
// run            | no HLT in flight, normal issue
// pending        | HLT accepted from ID, IF frozen while it drains to WB
// halted         | HLT reached WB, IF frozen until reset
module mips32_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int HAZARD_DEPTH = 1,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [31:0]      i_id_instr,
  input  logic             i_ex_br_taken,
  output logic             o_stall_if,
  output logic             o_bubble_ex,
  output logic             o_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt
);

  shadow_t          r_sh [SH_STAGES];  // 0 = EX, 1 = MEM, 2 = WB
  logic             r_halt_pending;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;

  instr_class_e         w_class;
  logic                 w_src1_use, w_src2_use, w_dest_use;
  logic [4:0]           w_src1_idx, w_src2_idx, w_dest_idx;
  logic [SH_STAGES-1:0] w_stage_hit;
  logic                 w_raw_hz, w_halted, w_hold;
  logic                 w_stall, w_accept, w_count;
  shadow_t              w_sh_ex_next, w_sh_mem_next;

  mips32_instr_decode u_decode (
    .i_instr    (i_id_instr),
    .o_class    (w_class),
    .o_src1_use (w_src1_use),
    .o_src1_idx (w_src1_idx),
    .o_src2_use (w_src2_use),
    .o_src2_idx (w_src2_idx),
    .o_dest_use (w_dest_use),
    .o_dest_idx (w_dest_idx)
  );

  // Compare ID sources against the shadow stages enabled by HAZARD_DEPTH
  always_comb begin
    w_stage_hit = '0;
    for (int k = 0; k < SH_STAGES; k++) begin
      if (k < HAZARD_DEPTH && r_sh[k].valid) begin
        w_stage_hit[k] = src_match(w_src1_use, w_src1_idx, r_sh[k].dest) ||
                         src_match(w_src2_use, w_src2_idx, r_sh[k].dest);
      end
    end
  end

  // The HLT token in WB makes halted visible in the same cycle it arrives
  assign w_halted = r_halted | r_sh[2].is_hlt;
  assign w_hold   = r_halt_pending | w_halted;
  assign w_raw_hz = i_id_valid & (|w_stage_hit);

  // Priority: flush > halt hold > RAW stall > issue; halted always freezes IF
  always_comb begin
    w_stall  = 1'b0;
    w_accept = 1'b0;
    w_count  = 1'b0;
    if (i_ex_br_taken) begin
      w_stall = 1'b0;
    end else if (w_hold) begin
      w_stall = 1'b1;
    end else if (w_raw_hz) begin
      w_stall = 1'b1;
      w_count = 1'b1;
    end else begin
      w_accept = i_id_valid;
    end
    if (w_halted) begin
      w_stall = 1'b1;
    end
  end

  // Next shadow entries; a taken branch squashes a HLT that has only reached EX
  always_comb begin
    w_sh_ex_next = SH_BUBBLE;
    if (w_accept) begin
      w_sh_ex_next.valid  = w_dest_use && (w_dest_idx != 5'd0);
      w_sh_ex_next.dest   = w_dest_idx;
      w_sh_ex_next.is_hlt = (w_class == CLS_HALT);
    end
    w_sh_mem_next = r_sh[0];
    if (i_ex_br_taken) begin
      w_sh_mem_next.is_hlt = 1'b0;
    end
  end

  // Shadow pipe, halt sequencer and saturating stall counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SH_STAGES; k++) begin
        r_sh[k] <= SH_BUBBLE;
      end
      r_halt_pending <= 1'b0;
      r_halted       <= 1'b0;
      r_stall_cnt    <= '0;
    end else begin
      r_sh[0] <= w_sh_ex_next;
      r_sh[1] <= w_sh_mem_next;
      r_sh[2] <= r_sh[1];
      if (i_ex_br_taken) begin
        r_halt_pending <= 1'b0;
      end else if (w_accept && w_sh_ex_next.is_hlt) begin
        r_halt_pending <= 1'b1;
      end
      r_halted <= w_halted;
      if (w_count && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_if  = w_stall;
  assign o_bubble_ex = w_stall;
  assign o_flush     = i_ex_br_taken;
  assign o_halted    = w_halted;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Bench for mips32_hazard_ctrl: three instances (depth 1/2/3, the last with a
// 3-bit counter) share one stimulus stream and are compared every cycle against
// an instruction-history reference model, plus directed scenario checks.
module tb_mips32_hazard_ctrl;
  import mips32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, ex_br_taken;
  logic [31:0] id_instr;
  logic        stall_o [3];
  logic        bubble_o [3];
  logic        flush_o [3];
  logic        halted_o [3];
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic [15:0] cnt_o [3];

  assign cnt_o[0] = cnt0;
  assign cnt_o[1] = cnt1;
  assign cnt_o[2] = {13'd0, cnt2};

  always #5 clk = ~clk;

  mips32_hazard_ctrl #(.HAZARD_DEPTH(1), .CNT_W(16)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_ex_br_taken(ex_br_taken), .o_stall_if(stall_o[0]), .o_bubble_ex(bubble_o[0]),
    .o_flush(flush_o[0]), .o_halted(halted_o[0]), .o_stall_cnt(cnt0));

  mips32_hazard_ctrl #(.HAZARD_DEPTH(2), .CNT_W(16)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_ex_br_taken(ex_br_taken), .o_stall_if(stall_o[1]), .o_bubble_ex(bubble_o[1]),
    .o_flush(flush_o[1]), .o_halted(halted_o[1]), .o_stall_cnt(cnt1));

  mips32_hazard_ctrl #(.HAZARD_DEPTH(3), .CNT_W(3)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_ex_br_taken(ex_br_taken), .o_stall_if(stall_o[2]), .o_bubble_ex(bubble_o[2]),
    .o_flush(flush_o[2]), .o_halted(halted_o[2]), .o_stall_cnt(cnt2));

  // Reference model: per instance, the last three instructions that entered EX
  // (index 0 newest), a halt-pending flag, the halted flag and the stall count.
  typedef struct packed { bit v; bit [4:0] d; bit h; } ent_t;
  ent_t        m_sh [3][3];
  bit          m_hp [3];
  bit          m_halted [3];
  int unsigned m_cnt [3];
  int          depth [3];
  int unsigned cnt_max [3];

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned sum_stall [3];
  logic        ob_stall [3];
  logic        ob_flush [3];
  logic        ob_halted [3];

  logic [5:0]  ops [15];

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Register usage straight from the opcode table
  function automatic void mdec(input logic [31:0] ins, output bit u1, output bit [4:0] s1,
                               output bit u2, output bit [4:0] s2, output bit dv,
                               output bit [4:0] dd, output bit hl);
    bit [5:0] op;
    op = ins[31:26];
    u1 = 1'b0; u2 = 1'b0; dv = 1'b0; hl = 1'b0; dd = 5'd0;
    s1 = ins[25:21];
    s2 = ins[20:16];
    if (op <= 6'h05) begin
      u1 = 1'b1; u2 = 1'b1; dv = 1'b1; dd = ins[15:11];
    end else if (op == 6'h08 || (op >= 6'h0A && op <= 6'h0C)) begin
      u1 = 1'b1; dv = 1'b1; dd = ins[20:16];
    end else if (op == 6'h09) begin
      u1 = 1'b1; u2 = 1'b1;
    end else if (op == 6'h0D || op == 6'h0E) begin
      u1 = 1'b1;
    end else if (op == 6'h3F) begin
      hl = 1'b1;
    end
    if (dd == 5'd0) dv = 1'b0;
  endfunction

  task automatic reset_model(input int d);
    for (int k = 0; k < 3; k++) m_sh[d][k] = '0;
    m_hp[d]     = 1'b0;
    m_halted[d] = 1'b0;
    m_cnt[d]    = 0;
  endtask

  task automatic check(input string tag, input int d, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One clock: drive inputs, check every instance at the falling edge, advance model
  task automatic step(input logic v, input logic [31:0] ins, input logic br,
                      input logic rstn);
    bit u1, u2, dv, hl, raw, hold, acc, cnt_en, e_stall;
    bit [4:0] s1, s2, dd;
    ent_t e, ne;
    id_valid = v; id_instr = ins; ex_br_taken = br; rst_n = rstn;
    @(negedge clk);
    mdec(ins, u1, s1, u2, s2, dv, dd, hl);
    for (int d = 0; d < 3; d++) begin
      raw = 1'b0;
      for (int k = 0; k < depth[d]; k++) begin
        e = m_sh[d][k];
        if (e.v && ((u1 && s1 != 5'd0 && s1 == e.d) || (u2 && s2 != 5'd0 && s2 == e.d)))
          raw = 1'b1;
      end
      raw     = raw && v;
      hold    = m_hp[d] || m_halted[d];
      e_stall = m_halted[d] ? 1'b1 : (br ? 1'b0 : (hold || raw));
      acc     = v && !br && !hold && !raw;
      cnt_en  = !br && !hold && raw;
      check("stall_if",  d, 16'(stall_o[d]),  16'(e_stall));
      check("bubble_ex", d, 16'(bubble_o[d]), 16'(e_stall));
      check("flush",     d, 16'(flush_o[d]),  16'(br));
      check("halted",    d, 16'(halted_o[d]), 16'(m_halted[d]));
      check("stall_cnt", d, cnt_o[d],         16'(m_cnt[d]));
      ob_stall[d]  = stall_o[d];
      ob_flush[d]  = flush_o[d];
      ob_halted[d] = halted_o[d];
      if (stall_o[d] === 1'b1) sum_stall[d]++;
      if (!rstn) begin
        reset_model(d);
      end else begin
        if (m_sh[d][1].h) m_halted[d] = 1'b1;
        m_sh[d][2] = m_sh[d][1];
        m_sh[d][1] = m_sh[d][0];
        if (br) m_sh[d][1].h = 1'b0;
        ne.v = acc && dv;
        ne.d = dd;
        ne.h = acc && hl;
        m_sh[d][0] = ne;
        if (br) m_hp[d] = 1'b0;
        else if (acc && hl) m_hp[d] = 1'b1;
        if (cnt_en && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) sum_stall[d] = 0;
  endtask

  // Present an instruction until instance d stops stalling on it (bounded)
  task automatic issue(input logic [31:0] ins, input int d);
    int tries;
    tries = 0;
    do begin
      step(1'b1, ins, 1'b0, 1'b1);
      tries++;
    end while (ob_stall[d] !== 1'b0 && tries < 8);
    check("issue_accepted", d, 16'(ob_stall[d]), 16'd0);
  endtask

  initial begin
    logic [31:0] hlt, addi_r1, lw_r2, or_r3, add_r5;
    logic [31:0] rin;
    logic        rv, rbr, rrst;
    depth   = '{1, 2, 3};
    cnt_max = '{65535, 65535, 7};
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h10, 6'h07};
    hlt     = {OP_HLT, 26'd0};
    addi_r1 = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd120);
    lw_r2   = enc_i(OP_LW, 5'd1, 5'd2, 16'd0);
    or_r3   = enc_r(OP_OR, 5'd3, 5'd3, 5'd3);
    add_r5  = enc_r(OP_ADD, 5'd1, 5'd1, 5'd5);
    for (int d = 0; d < 3; d++) begin
      reset_model(d);
      sum_stall[d] = 0;
    end
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; ex_br_taken = 1'b0;
    @(posedge clk);
    #1;

    // ADDI R1 then LW using R1, back to back
    do_reset();
    issue(addi_r1, 0);
    issue(lw_r2, 0);
    idle(1);
    check("t1_stall_clks", 0, 16'(sum_stall[0]), 16'd1);
    check("t1_stall_cnt", 0, cnt_o[0], 16'd1);

    // Same pair with one independent instruction between
    do_reset();
    issue(addi_r1, 0);
    issue(or_r3, 0);
    issue(lw_r2, 0);
    idle(1);
    check("t2_stall_clks", 0, 16'(sum_stall[0]), 16'd0);
    check("t2_stall_cnt", 0, cnt_o[0], 16'd0);
    check("t2_stall_clks_d2", 1, 16'(sum_stall[1]), 16'd1);
    check("t2_stall_cnt_d2", 1, cnt_o[1], 16'd1);

    // R0 is never a hazard
    do_reset();
    issue(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5), 2);
    issue(enc_r(OP_ADD, 5'd0, 5'd0, 5'd4), 2);
    idle(1);
    check("t3_stall_clks_d3", 2, 16'(sum_stall[2]), 16'd0);
    check("t3_stall_cnt_d3", 2, cnt_o[2], 16'd0);

    // Taken branch with a dependent SW in ID
    do_reset();
    issue(addi_r1, 0);
    step(1'b1, enc_i(OP_SW, 5'd1, 5'd2, 16'd1), 1'b1, 1'b1);
    check("t4_flush", 0, 16'(ob_flush[0]), 16'd1);
    check("t4_stall", 0, 16'(ob_stall[0]), 16'd0);
    idle(1);
    check("t4_stall_cnt", 0, cnt_o[0], 16'd0);

    // HLT sequencing: stall from N+1, halted from N+3, sticky
    do_reset();
    step(1'b1, hlt, 1'b0, 1'b1);
    idle(1);
    check("t5_stall_n1", 0, 16'(ob_stall[0]), 16'd1);
    check("t5_halted_n1", 0, 16'(ob_halted[0]), 16'd0);
    idle(1);
    check("t5_halted_n2", 0, 16'(ob_halted[0]), 16'd0);
    idle(1);
    check("t5_halted_n3", 0, 16'(ob_halted[0]), 16'd1);
    idle(4);
    check("t5_halted_sticky", 0, 16'(ob_halted[0]), 16'd1);
    check("t5_stall_sticky", 0, 16'(ob_stall[0]), 16'd1);

    // Taken branch right after HLT cancels the halt
    do_reset();
    step(1'b1, hlt, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    idle(5);
    check("t5b_halted", 0, 16'(ob_halted[0]), 16'd0);
    check("t5b_stall", 0, 16'(ob_stall[0]), 16'd0);

    // Reset in the middle of a stall
    do_reset();
    issue(addi_r1, 0);
    step(1'b1, add_r5, 1'b0, 1'b0);
    check("t6_stall_before_rst", 0, 16'(ob_stall[0]), 16'd1);
    idle(1);
    check("t6_stall_after_rst", 0, 16'(ob_stall[0]), 16'd0);
    check("t6_cnt_after_rst", 0, cnt_o[0], 16'd0);

    // Counter saturation on the 3-bit instance, then reset clears it
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(addi_r1, 2);
      issue(add_r5, 2);
    end
    check("t6_sat_d3", 2, cnt_o[2], 16'd7);
    check("t6_cnt_d1", 0, cnt_o[0], 16'd4);
    check("t6_cnt_d2", 1, cnt_o[1], 16'd8);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    idle(1);
    check("t6_sat_reset", 2, cnt_o[2], 16'd0);

    // Randomized traffic over a small register set
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rbr  = ($urandom_range(0, 9) == 0);
      rrst = ($urandom_range(0, 149) != 0);
      rin  = enc_r(ops[$urandom_range(0, 14)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) rin = hlt;
      step(rv, rin, rbr, rrst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
